regfile_read_stage: RTL and testbench

//  Register-file read stage of the pipelined CPU, directly downstream of the 32x64 register array.
//  - Selects two source operands (A, B) from the flattened register outputs.
//  - Bypasses a same-edge writeback, so a read never returns stale data.
//  - Forces register 31 to zero.
//  - Holds the operands in an ID/EX-style output register with valid/ready flow control and flush.

---
 rtl/regfile_read_stage.sv | 106 ++++++++++
 tb/tb_regfile_read_stage.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_read_stage.sv
// Register-file read stage: operand select with same-edge writeback bypass and r31 = 0.
// Latency 1 cycle; valid/ready output register, flush kills stage and input, in_ready = !out_valid | out_ready | flush.
// Optional REGREAD_HOLD_REFRESH_EN: a writeback landing during a stall refreshes the held operands.
module regfile_read_stage #(
    parameter int DATA_W   = 64,
    parameter int NREGS    = 32,
    parameter int ADDR_W   = $clog2(NREGS),
    parameter int ZERO_REG = 31
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREGS*DATA_W-1:0] read_list,
    input  logic [ADDR_W-1:0]       rd_addr_a,
    input  logic [ADDR_W-1:0]       rd_addr_b,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    wb_en,
    input  logic [ADDR_W-1:0]       wb_addr,
    input  logic [DATA_W-1:0]       wb_data,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data_a,
    output logic [DATA_W-1:0]       out_data_b,
    output logic [ADDR_W-1:0]       out_addr_a,
    output logic [ADDR_W-1:0]       out_addr_b
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] w_regs [NREGS];
    logic [DATA_W-1:0] w_data_a;
    logic [DATA_W-1:0] w_data_b;
    logic              w_accept;

    logic              r_vld;
    logic [DATA_W-1:0] r_data_a;
    logic [DATA_W-1:0] r_data_b;
    logic [ADDR_W-1:0] r_addr_a;
    logic [ADDR_W-1:0] r_addr_b;

    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            w_regs[i] = read_list[i*DATA_W +: DATA_W];
        end
    end

    // Zero register beats the bypass, so a write to r31 can never leak through.
    always_comb begin
        w_data_a = w_regs[rd_addr_a];
        if (rd_addr_a == ZERO_ADDR) begin
            w_data_a = '0;
        end else if (wb_en && (wb_addr == rd_addr_a)) begin
            w_data_a = wb_data;
        end
    end

    always_comb begin
        w_data_b = w_regs[rd_addr_b];
        if (rd_addr_b == ZERO_ADDR) begin
            w_data_b = '0;
        end else if (wb_en && (wb_addr == rd_addr_b)) begin
            w_data_b = wb_data;
        end
    end

    assign in_ready = !r_vld || out_ready || flush;
    assign w_accept = in_valid && in_ready && !flush;

    // Flush only drops valid; data/addr are left as they were.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vld    <= 1'b0;
            r_data_a <= '0;
            r_data_b <= '0;
            r_addr_a <= '0;
            r_addr_b <= '0;
        end else if (flush) begin
            r_vld <= 1'b0;
        end else if (w_accept) begin
            r_vld    <= 1'b1;
            r_data_a <= w_data_a;
            r_data_b <= w_data_b;
            r_addr_a <= rd_addr_a;
            r_addr_b <= rd_addr_b;
        end else if (r_vld && out_ready) begin
            r_vld <= 1'b0;
`ifdef REGREAD_HOLD_REFRESH_EN
        end else if (r_vld && wb_en && (wb_addr != ZERO_ADDR)) begin
            if (wb_addr == r_addr_a) begin
                r_data_a <= wb_data;
            end
            if (wb_addr == r_addr_b) begin
                r_data_b <= wb_data;
            end
`endif
        end
    end

    assign out_valid  = r_vld;
    assign out_data_a = r_data_a;
    assign out_data_b = r_data_b;
    assign out_addr_a = r_addr_a;
    assign out_addr_b = r_addr_b;

endmodule

// File: tb/tb_regfile_read_stage.sv
// Bench for regfile_read_stage: operand-select vector table plus stall/refresh/flush/reset sequences.
// A sampling process models valid/ready and scoreboards every operand pair the stage delivers.
module tb_regfile_read_stage;

    localparam int DATA_W = 64;
    localparam int NREGS  = 32;
    localparam int ADDR_W = 5;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NREGS*DATA_W-1:0] read_list;
    logic [ADDR_W-1:0]       rd_addr_a, rd_addr_b;
    logic                    in_valid, in_ready;
    logic                    wb_en;
    logic [ADDR_W-1:0]       wb_addr;
    logic [DATA_W-1:0]       wb_data;
    logic                    flush;
    logic                    out_valid, out_ready;
    logic [DATA_W-1:0]       out_data_a, out_data_b;
    logic [ADDR_W-1:0]       out_addr_a, out_addr_b;

    logic [DATA_W-1:0]       cur_ea, cur_eb;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [ADDR_W-1:0] ra;
        logic [ADDR_W-1:0] rb;
        logic              we;
        logic [ADDR_W-1:0] wa;
        logic [DATA_W-1:0] wd;
        logic [DATA_W-1:0] ea;
        logic [DATA_W-1:0] eb;
    } vec_t;

    typedef struct {
        logic [ADDR_W-1:0] aa;
        logic [ADDR_W-1:0] ab;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } exp_t;

    exp_t sb[$];
    logic exp_vld = 1'b0;

    regfile_read_stage dut (
        .clk        (clk),
        .reset      (reset),
        .read_list  (read_list),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data_a (out_data_a),
        .out_data_b (out_data_b),
        .out_addr_a (out_addr_a),
        .out_addr_b (out_addr_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic iv, input logic ordy, input logic fl,
                         input logic [ADDR_W-1:0] ra, input logic [ADDR_W-1:0] rb,
                         input logic we, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                         input logic [DATA_W-1:0] ea, input logic [DATA_W-1:0] eb);
        @(negedge clk);
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        rd_addr_a = ra;
        rd_addr_b = rb;
        wb_en     = we;
        wb_addr   = wa;
        wb_data   = wd;
        cur_ea    = ea;
        cur_eb    = eb;
    endtask

    // Sampler: 1 ns before each rising edge, after inputs have settled.
    initial begin
        logic rdy;
        logic consume;
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (!reset) begin
                chk("reset_out_valid", out_valid, 0);
                exp_vld = 1'b0;
                sb.delete();
            end else begin
                chk("out_valid", out_valid, exp_vld);
                rdy = !exp_vld || out_ready || flush;
                chk("in_ready", in_ready, rdy);
                if (exp_vld) begin
                    chk("sb_depth", sb.size(), 1);
                    if (sb.size() > 0) begin
                        chk("out_data_a", out_data_a, sb[0].a);
                        chk("out_data_b", out_data_b, sb[0].b);
                        chk("out_addr_a", out_addr_a, sb[0].aa);
                        chk("out_addr_b", out_addr_b, sb[0].ab);
                    end
                end
                if (flush) begin
                    exp_vld = 1'b0;
                    sb.delete();
                end else begin
                    consume = exp_vld && out_ready;
                    if (consume) begin
                        if (sb.size() > 0) e = sb.pop_front();
                    end
`ifdef REGREAD_HOLD_REFRESH_EN
                    else if (exp_vld && wb_en && wb_addr != 5'd31 && sb.size() > 0) begin
                        if (wb_addr == sb[0].aa) sb[0].a = wb_data;
                        if (wb_addr == sb[0].ab) sb[0].b = wb_data;
                    end
`endif
                    if (in_valid && rdy) begin
                        e.aa = rd_addr_a;
                        e.ab = rd_addr_b;
                        e.a  = cur_ea;
                        e.b  = cur_eb;
                        sb.push_back(e);
                        exp_vld = 1'b1;
                    end else if (consume) begin
                        exp_vld = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        vec_t vecs[7];
        logic [63:0] held_a;
        vecs[0] = '{5'd3,  5'd7,  1'b0, 5'd0,  64'h0,     64'h1111,                64'h2222};
        vecs[1] = '{5'd5,  5'd5,  1'b1, 5'd5,  64'hDEAD,  64'hDEAD,                64'hDEAD};
        vecs[2] = '{5'd31, 5'd31, 1'b1, 5'd31, 64'hFFFF,  64'h0,                   64'h0};
        vecs[3] = '{5'd0,  5'd30, 1'b0, 5'd0,  64'h1234,  64'hA5A5_0000_0000_0000, 64'hA5A5_0000_0000_001E};
        vecs[4] = '{5'd12, 5'd9,  1'b1, 5'd9,  64'hCAFE,  64'hA5A5_0000_0000_000C, 64'hCAFE};
        vecs[5] = '{5'd8,  5'd8,  1'b0, 5'd8,  64'h77,    64'hA5A5_0000_0000_0008, 64'hA5A5_0000_0000_0008};
        vecs[6] = '{5'd31, 5'd2,  1'b1, 5'd2,  64'h4242,  64'h0,                   64'h4242};

        for (int i = 0; i < NREGS; i++) begin
            read_list[i*DATA_W +: DATA_W] = 64'hA5A5_0000_0000_0000 | 64'(i);
        end
        read_list[3*DATA_W +: DATA_W] = 64'h1111;
        read_list[7*DATA_W +: DATA_W] = 64'h2222;
        read_list[5*DATA_W +: DATA_W] = 64'h0;

        in_valid = 0; out_ready = 0; flush = 0; rd_addr_a = 0; rd_addr_b = 0;
        wb_en = 0; wb_addr = 0; wb_data = 0; cur_ea = 0; cur_eb = 0;

        // Reset state
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_data_a", out_data_a, 0);
        chk("rst_data_b", out_data_b, 0);
        chk("rst_addr_a", out_addr_a, 0);
        chk("rst_addr_b", out_addr_b, 0);
        chk("rst_in_ready", in_ready, 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Back-to-back operand table
        foreach (vecs[i]) begin
            drive(1, 1, 0, vecs[i].ra, vecs[i].rb, vecs[i].we, vecs[i].wa, vecs[i].wd,
                  vecs[i].ea, vecs[i].eb);
        end
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Stall holding a=4, b=7, with a competing request waiting
        drive(1, 0, 0, 5'd4, 5'd7, 0, 0, 0, 64'hA5A5_0000_0000_0004, 64'h2222);
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 0, 5'd1, 5'd2, 0, 0, 0, 64'hA5A5_0000_0000_0001, 64'hA5A5_0000_0000_0002);
            #4;
            chk("stall_in_ready", in_ready, 0);
            chk("stall_valid", out_valid, 1);
            chk("stall_data_a", out_data_a, 64'hA5A5_0000_0000_0004);
            chk("stall_data_b", out_data_b, 64'h2222);
        end
        drive(1, 0, 0, 5'd1, 5'd2, 1, 5'd4, 64'hBEEF, 64'hA5A5_0000_0000_0001, 64'hA5A5_0000_0000_0002);
        #4 chk("pre_wb_data_a", out_data_a, 64'hA5A5_0000_0000_0004);
`ifdef REGREAD_HOLD_REFRESH_EN
        held_a = 64'hBEEF;
`else
        held_a = 64'hA5A5_0000_0000_0004;
`endif
        drive(1, 1, 0, 5'd1, 5'd2, 0, 0, 0, 64'hA5A5_0000_0000_0001, 64'hA5A5_0000_0000_0002);
        #4;
        chk("stall_wb_data_a", out_data_a, held_a);
        chk("stall_wb_data_b", out_data_b, 64'h2222);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #4;
        chk("no_bubble_valid", out_valid, 1);
        chk("no_bubble_data_a", out_data_a, 64'hA5A5_0000_0000_0001);

        // Flush while stalled with a concurrent request
        drive(1, 0, 1, 5'd6, 5'd6, 0, 0, 0, 64'hA5A5_0000_0000_0006, 64'hA5A5_0000_0000_0006);
        #4 chk("flush_in_ready", in_ready, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #4;
        chk("flush_valid", out_valid, 0);
        chk("flush_keeps_data_a", out_data_a, 64'hA5A5_0000_0000_0001);

        // Reset pulsed mid-stall
        drive(1, 0, 0, 5'd3, 5'd7, 0, 0, 0, 64'h1111, 64'h2222);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2 reset = 1'b0;
        #1;
        chk("midstall_rst_valid", out_valid, 0);
        chk("midstall_rst_data_a", out_data_a, 0);
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        drive(1, 1, 0, 5'd0, 5'd31, 0, 0, 0, 64'hA5A5_0000_0000_0000, 64'h0);
        repeat (3) drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
